// File: rtl/seq_mac_mult.sv
// seq_mac_mult
//   Iterative multiply-accumulate: P = A*B + C, unsigned or two's-complement
//   per operation. One shift-add step per cycle over W cycles, then a final
//   cycle that applies the sign, adds C and derives the overflow flag.
//
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : operation request, honoured only while busy=0
//   sgn   : 0 unsigned, 1 two's-complement (captured with start)
//   A, B  : W-bit multiplicand / multiplier (captured with start)
//   C     : 2W-bit addend, signed iff sgn=1 (captured with start)
//   busy  : operation in progress
//   done  : one-cycle pulse, P and Co valid
//   P     : low 2W bits of A*B + C (held until the next result)
//   Co    : unsigned carry out of bit 2W-1, or signed range overflow
module seq_mac_mult #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [2*W-1:0]   C,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   P,
  output logic             Co
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            sgn_r;
  logic            neg_r;
  logic [2*W-1:0]  c_r;
  logic [2*W-1:0]  mc_r;
  logic [W-1:0]    mp_r;
  logic [2*W-1:0]  acc_r;

  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic [2*W+1:0]  prod_ext;
  logic [2*W+1:0]  c_ext;
  logic [2*W+1:0]  sum;
  logic [2:0]      top3;
  logic            ovf;

  // Signed mode runs sign-magnitude: magnitudes are taken as unsigned W-bit
  // values, so -2^(W-1) becomes 2^(W-1) without any loss.
  always_comb begin
    a_mag = A;
    b_mag = B;
    if (sgn && A[W-1]) a_mag = ~A + 1'b1;
    if (sgn && B[W-1]) b_mag = ~B + 1'b1;
  end

  // Final combine is done two bits wider than the result so the exact sum is
  // always representable; overflow is then read from the extra top bits.
  always_comb begin
    prod_ext = {2'b00, acc_r};
    if (neg_r) prod_ext = ~{2'b00, acc_r} + 1'b1;
    c_ext = {2'b00, c_r};
    if (sgn_r) c_ext = {{2{c_r[2*W-1]}}, c_r};
    sum  = prod_ext + c_ext;
    top3 = sum[2*W+1:2*W-1];
    if (sgn_r) ovf = !((top3 == 3'b000) || (top3 == 3'b111));
    else       ovf = sum[2*W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      P     <= '0;
      Co    <= 1'b0;
      sgn_r <= 1'b0;
      neg_r <= 1'b0;
      c_r   <= '0;
      mc_r  <= '0;
      mp_r  <= '0;
      acc_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sgn_r <= sgn;
            neg_r <= sgn & (A[W-1] ^ B[W-1]);
            c_r   <= C;
            mc_r  <= {{W{1'b0}}, a_mag};
            mp_r  <= b_mag;
            acc_r <= '0;
            cnt   <= CW'(W);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (mp_r[0]) acc_r <= acc_r + mc_r;
          mc_r <= mc_r << 1;
          mp_r <= mp_r >> 1;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIN;
        end
        FIN: begin
          P     <= sum[2*W-1:0];
          Co    <= ovf;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
